pipelined_cla_adder: RTL and testbench
======================================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 4, otherwise elaboration SHALL fail.
REQ-002 Derived constant NG = WIDTH/4 SHALL give the number of 4-bit carry-lookahead groups, which is also the pipeline depth.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts; a transfer occurs on a rising edge with out_valid && out_ready.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 busy  output  1  high while any pipeline stage holds a valid transaction.

Function
REQ-017 Stage k (k = 0..NG-1) SHALL compute bits [4k+3:4k] with a 4-bit carry-lookahead cell (generate/propagate, no internal ripple), using the carry registered by stage k-1 (stage 0 uses cin or 1).
REQ-018 Unprocessed upper operand bits and completed lower sum bits SHALL be carried in skew registers alongside each stage's valid bit.
REQ-019 Latency: an operand set accepted on edge t SHALL appear on sum/cout/ovf with out_valid=1 after edge t+NG-1 (NG edges including the accepting edge).
REQ-020 Global advance = !out_valid || out_ready; all stage registers SHALL shift only when advance=1, otherwise hold.
REQ-021 in_ready SHALL equal advance && !rst (combinational).
REQ-022 Throughput SHALL be one result per cycle when out_ready is held high; bubbles (in_valid=0) SHALL propagate as invalid stages without corrupting neighbours.
REQ-023 sum/cout/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Results SHALL leave in acceptance order; no transaction SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 Arithmetic: {cout,sum} SHALL equal a + b + cin (sub=0) or a + ~b + 1 (sub=1), modulo 2^(WIDTH+1).
REQ-026 Carry chain across all groups (e.g. all-ones + 1) SHALL resolve correctly with no extra latency.
REQ-027 busy SHALL be the OR of all stage valid bits including the output stage.

Reset
REQ-028 While rst=1 on an edge, all stage valid bits, out_valid, sum, cout, ovf and busy SHALL become 0 and all in-flight transactions SHALL be discarded.
REQ-029 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-030 Reset asserted mid-stream SHALL take effect on that edge regardless of out_ready; no stale result SHALL appear afterwards.

Verification
REQ-031 WIDTH=4: a=1010, b=1010, cin=0, sub=0 -> {cout,sum}=1_0100 with out_valid 1 edge after acceptance; a=1001, b=1110 -> 1_0111.
REQ-032 WIDTH=16: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 after 4 edges; 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 WIDTH=16, sub=1: 0x000C - 0x000A -> 0x0002, cout=1; 0x000A - 0x000C -> 0xFFFE, cout=0, ovf=0; cin=1 ignored in both.
REQ-034 Streaming: 8 back-to-back transfers with out_ready=1 -> 8 results on consecutive cycles in order; then out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after pipeline fills, output held stable, no loss on release.
REQ-035 Reset mid-operation: 3 transactions in flight, rst=1 one edge -> out_valid=0, busy=0, sum=0 next cycle; no stale results afterwards.
REQ-036 Random: 10,000 random a/b/cin/sub with random in_valid/out_ready, WIDTH in {4,8,16,32} -> every result matches the REQ-025 model in order.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit CLA group per stage, with a valid/ready handshake.
// Operand bits a stage has not yet consumed travel in shrinking skew registers; finished sum bits collect in growing ones.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NG = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = x & y;
    p = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic             advance;
  logic [NG-1:0]    vld;
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign busy     = |vld;
  // Subtraction is A + ~B + 1, so cin is replaced by the forced 1.
  assign b_eff    = sub ? ~b : b;
  assign c_first  = sub ? 1'b1 : cin;

  for (genvar k = 0; k < NG; k++) begin : stg
    localparam int RW = WIDTH - 4 * (k + 1);
    localparam bit LAST = (k == NG - 1);

    logic [3:0]     x;
    logic [3:0]     y;
    logic           ci;
    logic           vld_in;
    logic [4:0]     r;
    logic [4*k+3:0] nxt_sum;
    logic           vld_p;
    logic           cry_p;
    logic [4*k+3:0] sum_p;

    if (k == 0) begin : src
      assign x       = a[3:0];
      assign y       = b_eff[3:0];
      assign ci      = c_first;
      assign vld_in  = in_valid;
      assign nxt_sum = r[3:0];
    end else begin : src
      assign x       = stg[k-1].rem.a_p[3:0];
      assign y       = stg[k-1].rem.b_p[3:0];
      assign ci      = stg[k-1].cry_p;
      assign vld_in  = stg[k-1].vld_p;
      assign nxt_sum = {r[3:0], stg[k-1].sum_p};
    end

    assign r      = cla4(x, y, ci);
    assign vld[k] = vld_p;

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) vld_p <= 1'b0;
      else if (advance) vld_p <= vld_in;
    end

    always_ff @(posedge clk) begin
      if (LAST && rst) begin
        sum_p <= '0;
        cry_p <= 1'b0;
      end else if (advance) begin
        sum_p <= nxt_sum;
        cry_p <= r[4];
      end
    end

    if (!LAST) begin : rem
      logic [RW-1:0] a_p;
      logic [RW-1:0] b_p;
      logic [RW-1:0] nxt_a;
      logic [RW-1:0] nxt_b;
      if (k == 0) begin : up
        assign nxt_a = a[WIDTH-1:4];
        assign nxt_b = b_eff[WIDTH-1:4];
      end else begin : up
        assign nxt_a = stg[k-1].rem.a_p[RW+3:4];
        assign nxt_b = stg[k-1].rem.b_p[RW+3:4];
      end
      always_ff @(posedge clk) begin
        if (advance) begin
          a_p <= nxt_a;
          b_p <= nxt_b;
        end
      end
    end else begin : outp
      logic ovf_p;
      // The carry into the MSB is recovered from the MSB sum bit: c3 = s3 ^ x3 ^ y3.
      always_ff @(posedge clk) begin
        if (rst) ovf_p <= 1'b0;
        else if (advance) ovf_p <= r[4] ^ (x[3] ^ y[3] ^ r[3]);
      end
    end
  end

  assign out_valid = vld[NG-1];
  assign sum       = stg[NG-1].sum_p;
  assign cout      = stg[NG-1].cry_p;
  assign ovf       = stg[NG-1].outp.ovf_p;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder at WIDTH 4, 8, 16 and 32, all driven by one shared stimulus stream.
// Each instance keeps an arithmetic reference queue; directed literals pin down latency and the corner cases.
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, cin, sub;
  logic [31:0] a32, b32;
  int          chk = 0;
  int          err = 0;
  bit          started = 1'b0;
  logic [33:0] held;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int W = 4 << gi;
    logic          in_ready_w, out_valid_w, cout_w, ovf_w, busy_w;
    logic [W-1:0]  sum_w;
    logic [33:0]   q[$];
    logic [33:0]   head;
    int            qn = 0;

    pipelined_cla_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .a(a32[W-1:0]), .b(b32[W-1:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid_w), .out_ready(out_ready),
      .sum(sum_w), .cout(cout_w), .ovf(ovf_w), .busy(busy_w)
    );

    // Expected {ovf, cout, sum} from plain integer arithmetic on signed/unsigned values.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic ci, input logic sb);
      longint mask, half, ua, ub, full, sm, sa, sbv, t;
      logic   ov;
      mask = (longint'(1) << W) - 1;
      half = longint'(1) << (W - 1);
      ua   = longint'(av) & mask;
      ub   = longint'(bv) & mask;
      full = sb ? ua + (~ub & mask) + 1 : ua + ub + longint'(ci);
      sm   = full & mask;
      sa   = (ua >= half) ? ua - (half << 1) : ua;
      sbv  = (ub >= half) ? ub - (half << 1) : ub;
      t    = sb ? sa - sbv : sa + sbv + longint'(ci);
      ov   = (t >= half) || (t < -half);
      return {ov, full[W], sm[31:0]};
    endfunction

    always @(posedge clk) begin
      if (rst) q.delete();
      else begin
        if (out_valid_w && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready_w) q.push_back(model(a32, b32, cin, sub));
      end
      qn   <= q.size();
      head <= (q.size() != 0) ? q[0] : '0;
    end
  end

  task automatic sbc(input string nm, input logic ov, input logic [33:0] got,
                     input int n, input logic [33:0] hd, input logic bsy);
    chk++;
    if (ov === 1'b1) begin
      if (n == 0 || got !== hd) begin
        err++;
        $display("FAIL %s result: got %h expected %h (queued %0d)", nm, got, hd, n);
      end
    end else if (ov !== 1'b0) begin
      err++;
      $display("FAIL %s out_valid: got %b expected 0/1", nm, ov);
    end
    chk++;
    if (bsy !== (n != 0)) begin
      err++;
      $display("FAIL %s busy: got %b expected %b", nm, bsy, (n != 0));
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (started) begin
      sbc("w4",  g[0].out_valid_w, {g[0].ovf_w, g[0].cout_w, 32'(g[0].sum_w)}, g[0].qn, g[0].head, g[0].busy_w);
      sbc("w8",  g[1].out_valid_w, {g[1].ovf_w, g[1].cout_w, 32'(g[1].sum_w)}, g[1].qn, g[1].head, g[1].busy_w);
      sbc("w16", g[2].out_valid_w, {g[2].ovf_w, g[2].cout_w, 32'(g[2].sum_w)}, g[2].qn, g[2].head, g[2].busy_w);
      sbc("w32", g[3].out_valid_w, {g[3].ovf_w, g[3].cout_w, 32'(g[3].sum_w)}, g[3].qn, g[3].head, g[3].busy_w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [33:0] got, input logic [33:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    a32 = av; b32 = bv; cin = ci; sub = sb; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic t16(input string nm, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                     input logic sb, input logic [15:0] es, input logic ec, input logic eo);
    send(av, bv, ci, sb);
    cyc();
    cyc();
    lit({nm, " early valid"}, g[2].out_valid_w, 0);
    cyc();
    lit({nm, " valid"}, g[2].out_valid_w, 1);
    lit({nm, " sum"}, g[2].sum_w, es);
    lit({nm, " cout"}, g[2].cout_w, ec);
    lit({nm, " ovf"}, g[2].ovf_w, eo);
    drain(10);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a32 = '0; b32 = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    started = 1'b1;
    cyc();
    lit("rst in_ready", g[2].in_ready_w, 0);
    lit("rst out_valid", g[2].out_valid_w, 0);
    lit("rst busy", g[2].busy_w, 0);
    lit("rst sum", g[2].sum_w, 0);
    lit("rst cout/ovf", {g[2].cout_w, g[2].ovf_w}, 0);
    rst = 1'b0;
    #1;
    lit("post-rst in_ready", g[2].in_ready_w, 1);

    send(32'hA, 32'hA, 1'b0, 1'b0);
    lit("w4 a+a valid", g[0].out_valid_w, 1);
    lit("w4 a+a", {g[0].cout_w, g[0].sum_w}, 5'h14);
    drain(10);
    send(32'h9, 32'hE, 1'b0, 1'b0);
    lit("w4 9+e valid", g[0].out_valid_w, 1);
    lit("w4 9+e", {g[0].cout_w, g[0].sum_w}, 5'h17);
    drain(10);

    t16("ffff+1", 32'hFFFF, 32'h1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    t16("7fff+1", 32'h7FFF, 32'h1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    t16("c-a",    32'hC,    32'hA, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    t16("a-c",    32'hA,    32'hC, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Eight back-to-back transfers: w16 results must appear on eight consecutive cycles.
    for (int i = 0; i < 14; i++) begin
      a32 = $urandom; b32 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      in_valid = (i < 8);
      cyc();
      lit($sformatf("stream valid %0d", i), g[2].out_valid_w, (i >= 3 && i <= 10));
    end

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a32 = $urandom; b32 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      cyc();
      if (i == 3) held = {g[2].ovf_w, g[2].cout_w, 32'(g[2].sum_w)};
      if (i >= 3) begin
        lit($sformatf("stall in_ready %0d", i), g[2].in_ready_w, 0);
        lit($sformatf("stall hold %0d", i), {g[2].ovf_w, g[2].cout_w, 32'(g[2].sum_w)}, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    lit("release busy w16", g[2].busy_w, 0);
    lit("release busy w32", g[3].busy_w, 0);

    for (int i = 0; i < 3; i++) begin
      a32 = $urandom; b32 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    lit("midrst out_valid", g[2].out_valid_w, 0);
    lit("midrst busy", g[2].busy_w, 0);
    lit("midrst sum", g[2].sum_w, 0);
    lit("midrst busy w32", g[3].busy_w, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      lit($sformatf("no stale %0d", i), {g[3].out_valid_w, g[2].out_valid_w}, 0);
    end

    for (int i = 0; i < 10000; i++) begin
      int r;
      r = $urandom_range(0, 15);
      a32 = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h7FFF_FFFF : $urandom;
      b32 = (r == 0 || r == 1) ? 32'h1 : (r == 2) ? 32'hFFFF_FFFF : $urandom;
      cin = 1'($urandom);
      sub = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);
    lit("final busy", {g[0].busy_w, g[1].busy_w, g[2].busy_w, g[3].busy_w}, 0);
    lit("final out_valid", {g[0].out_valid_w, g[1].out_valid_w, g[2].out_valid_w, g[3].out_valid_w}, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
